isb_prefetch_buffer: RTL and testbench
======================================

Name: isb_prefetch_buffer

Overview:
- Receiving end of the isb prefetch output: accepts prefetch candidates (valid + 16-bit address) from isb.
- Deduplicates candidates, queues them, issues them to memory with a valid/ready handshake, and tracks completions.
- Matches demand accesses against buffered prefetches, reporting timely and late hits.
- Sits between isb and the memory request port, alongside the demand path.

Parameters:
- DEPTH, 4, number of buffer entries (power of 2, 2..16).
- ADDR_W, 16, address width.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- pf_v  in  1  prefetch candidate valid (from isb).
- pf_addr  in  ADDR_W  prefetch candidate address.
- pf_drop  out  1  registered pulse: candidate discarded (duplicate or buffer full).
- mem_req_v  out  1  memory request valid.
- mem_req_addr  out  ADDR_W  memory request address.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_resp_v  in  1  memory fill returned.
- mem_resp_addr  in  ADDR_W  address of the returned fill.
- dem_v  in  1  demand access valid.
- dem_addr  in  ADDR_W  demand address.
- dem_hit  out  1  registered pulse: demand matched a READY entry.
- dem_late  out  1  registered pulse: demand matched a QUEUED or ISSUED entry.
- hit_cnt  out  16  saturating count of dem_hit pulses.

Behaviour:
- Each entry has an address tag and a 2-bit state: INVALID, QUEUED, ISSUED, READY.
- All matches and decisions in a cycle use the state at the start of that cycle. All updates take effect at the next posedge.
- Reset (rst_n=0, asynchronous):
  - All entries INVALID.
  - pf_drop, dem_hit and dem_late are 0; hit_cnt is 0.
  - mem_req_v is 0 as a consequence.
  - Reset mid-transaction discards all entries. Fills arriving after reset are ignored.
- Allocation (pf_v=1):
  - If pf_addr matches any non-INVALID entry, or equals dem_addr while dem_v=1 the same cycle, the candidate is dropped and pf_drop=1 next cycle.
  - Otherwise, the lowest-index INVALID entry becomes QUEUED with tag pf_addr.
  - If no entry is INVALID, the candidate is dropped and pf_drop=1. There is no replacement.
  - An entry freed this cycle is not allocatable until the next cycle.
- Issue:
  - mem_req_v=1 whenever any entry is QUEUED. mem_req_addr is the tag of the lowest-index QUEUED entry.
  - Both are decoded combinationally from registered state, so they are stable until accepted.
  - When mem_req_v and mem_req_ready are both 1, that entry becomes ISSUED.
  - Latency: a candidate accepted at edge N appears on mem_req in the cycle after edge N, if no lower-index entry is QUEUED.
- Fill:
  - mem_resp_v=1 with an address matching an ISSUED entry moves that entry to READY.
  - A fill matching no ISSUED entry is ignored silently.
- Demand (dem_v=1):
  - Match on a READY entry: dem_hit=1 next cycle, the entry becomes INVALID, and hit_cnt increments (holds at 16'hFFFF).
  - Match on a QUEUED or ISSUED entry: dem_late=1 next cycle and the entry becomes INVALID.
  - A later fill for a freed ISSUED entry is ignored.
  - If the freed entry is the one handshaking on mem_req the same cycle, the handshake completes (the request is sent) and the entry still becomes INVALID.
  - No match: no output pulse.
- Simultaneous events on the same entry in one cycle:
  - Demand free takes priority over fill (the entry ends INVALID).
  - Fill and issue cannot coincide on one entry.
- Tags are unique: dedup guarantees at most one entry matches any address.
- Output pulses last exactly one cycle per event and are 0 otherwise.

Test Plan:
- Reset, then pf_v=1 with pf_addr=0x0010 and mem_req_ready=0 -> mem_req_v=1, mem_req_addr=0x0010 the next cycle; held stable for 5 cycles; pf_drop=0.
- Candidates 0x0010 and 0x0011 on consecutive cycles, then 0x0010 again -> third candidate gives pf_drop=1. Requests go out as 0x0010 then 0x0011 with mem_req_ready=1.
- Issue 0x0010, mem_resp_v with mem_resp_addr=0x0010, then dem_v with dem_addr=0x0010 -> dem_hit=1 for one cycle, hit_cnt=1; a second demand to 0x0010 gives no pulse.
- DEPTH=4: five distinct candidates 0x0020..0x0024 with mem_req_ready=0 -> the fifth gives pf_drop=1. dem_v with dem_addr=0x0022 -> dem_late=1; a new candidate 0x0030 is accepted two cycles later.
- Issue 0x0040, demand 0x0040 before the fill -> dem_late=1. A later fill for 0x0040 is ignored (no READY entry; a following demand to 0x0040 gives no pulse).
- Assert rst_n=0 asynchronously mid-cycle with 3 entries live -> mem_req_v and all pulses drop to 0 immediately and hit_cnt=0. After release, a fill for an old address has no effect.

Source files
------------

// File: rtl/isb_prefetch_buffer.sv
// isb_prefetch_buffer: receives prefetch candidates from isb, filters
// duplicates, queues them toward the memory request port, tracks fills and
// scores demand accesses against buffered lines as timely or late hits.
module isb_prefetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pf_v,
  input  logic [ADDR_W-1:0] pf_addr,
  output logic              pf_drop,
  output logic              mem_req_v,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_v,
  input  logic [ADDR_W-1:0] mem_resp_addr,
  input  logic              dem_v,
  input  logic [ADDR_W-1:0] dem_addr,
  output logic              dem_hit,
  output logic              dem_late,
  output logic [15:0]       hit_cnt
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_QUEUED  = 2'd1,
    ST_ISSUED  = 2'd2,
    ST_READY   = 2'd3
  } ent_state_e;

  ent_state_e        state_r     [DEPTH];
  logic [ADDR_W-1:0] tag_r       [DEPTH];
  ent_state_e        state_nxt_s [DEPTH];

  logic [DEPTH-1:0] dem_match_s;
  logic             pf_dup_s;
  logic             free_found_s;
  logic [IW-1:0]    free_idx_s;
  logic             req_found_s;
  logic [IW-1:0]    req_idx_s;
  logic             dem_ready_s;
  logic             dem_pend_s;
  logic             alloc_s;
  logic             fire_s;

  logic             pf_drop_r;
  logic             dem_hit_r;
  logic             dem_late_r;
  logic [15:0]      hit_cnt_r;

  // Lookups against start-of-cycle state: dedup, free slot, issue head, demand match.
  always_comb begin
    pf_dup_s     = dem_v & (dem_addr == pf_addr);
    free_found_s = 1'b0;
    free_idx_s   = '0;
    req_found_s  = 1'b0;
    req_idx_s    = '0;
    dem_ready_s  = 1'b0;
    dem_pend_s   = 1'b0;
    dem_match_s  = '0;
    // Walk downward so the last assignment wins: lowest index has priority.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      pf_dup_s       = pf_dup_s | ((state_r[i] != ST_INVALID) & (tag_r[i] == pf_addr));
      free_found_s   = free_found_s | (state_r[i] == ST_INVALID);
      free_idx_s     = (state_r[i] == ST_INVALID) ? IW'(i) : free_idx_s;
      req_found_s    = req_found_s | (state_r[i] == ST_QUEUED);
      req_idx_s      = (state_r[i] == ST_QUEUED) ? IW'(i) : req_idx_s;
      dem_match_s[i] = dem_v & (state_r[i] != ST_INVALID) & (tag_r[i] == dem_addr);
      dem_ready_s    = dem_ready_s | (dem_match_s[i] & (state_r[i] == ST_READY));
      dem_pend_s     = dem_pend_s | (dem_match_s[i] & ((state_r[i] == ST_QUEUED) |
                                                       (state_r[i] == ST_ISSUED)));
    end
    alloc_s      = pf_v & ~pf_dup_s & free_found_s;
    fire_s       = req_found_s & mem_req_ready;
    mem_req_v    = req_found_s;
    mem_req_addr = tag_r[req_idx_s];
  end

  // Per-entry next state; a demand free overrides issue and fill on the same entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        ST_INVALID: begin
          state_nxt_s[i] = (alloc_s && (free_idx_s == IW'(i))) ? ST_QUEUED : ST_INVALID;
        end
        ST_QUEUED: begin
          if (dem_match_s[i]) begin
            state_nxt_s[i] = ST_INVALID;
          end else if (fire_s && (req_idx_s == IW'(i))) begin
            state_nxt_s[i] = ST_ISSUED;
          end else begin
            state_nxt_s[i] = ST_QUEUED;
          end
        end
        ST_ISSUED: begin
          if (dem_match_s[i]) begin
            state_nxt_s[i] = ST_INVALID;
          end else if (mem_resp_v && (tag_r[i] == mem_resp_addr)) begin
            state_nxt_s[i] = ST_READY;
          end else begin
            state_nxt_s[i] = ST_ISSUED;
          end
        end
        ST_READY: begin
          state_nxt_s[i] = dem_match_s[i] ? ST_INVALID : ST_READY;
        end
        default: begin
          state_nxt_s[i] = ST_INVALID;
        end
      endcase
    end
  end

  // Entry state and tag registers; the allocated slot captures the candidate address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_r[i] <= ST_INVALID;
        tag_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_r[i] <= state_nxt_s[i];
        if (alloc_s && (free_idx_s == IW'(i))) begin
          tag_r[i] <= pf_addr;
        end
      end
    end
  end

  // Registered event pulses and the saturating timely-hit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_drop_r  <= 1'b0;
      dem_hit_r  <= 1'b0;
      dem_late_r <= 1'b0;
      hit_cnt_r  <= 16'd0;
    end else begin
      pf_drop_r  <= pf_v & ~alloc_s;
      dem_hit_r  <= dem_ready_s;
      dem_late_r <= dem_pend_s;
      if (dem_ready_s && (hit_cnt_r != 16'hFFFF)) begin
        hit_cnt_r <= hit_cnt_r + 16'd1;
      end
    end
  end

  assign pf_drop  = pf_drop_r;
  assign dem_hit  = dem_hit_r;
  assign dem_late = dem_late_r;
  assign hit_cnt  = hit_cnt_r;

endmodule

// File: tb/tb_isb_prefetch_buffer.sv
// Directed table-driven bench for isb_prefetch_buffer (DEPTH=4, ADDR_W=16).
// Each record drives one cycle of inputs; outputs are checked 1ns after the
// following posedge. Asynchronous reset is exercised by hand-written sequences.
module tb_isb_prefetch_buffer;

  logic        clk;
  logic        rst_n;
  logic        pf_v;
  logic [15:0] pf_addr;
  logic        pf_drop;
  logic        mem_req_v;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_v;
  logic [15:0] mem_resp_addr;
  logic        dem_v;
  logic [15:0] dem_addr;
  logic        dem_hit;
  logic        dem_late;
  logic [15:0] hit_cnt;

  isb_prefetch_buffer #(.DEPTH(4), .ADDR_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pf_v          (pf_v),
    .pf_addr       (pf_addr),
    .pf_drop       (pf_drop),
    .mem_req_v     (mem_req_v),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_v    (mem_resp_v),
    .mem_resp_addr (mem_resp_addr),
    .dem_v         (dem_v),
    .dem_addr      (dem_addr),
    .dem_hit       (dem_hit),
    .dem_late      (dem_late),
    .hit_cnt       (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pv;
    logic [15:0] pa;
    logic        rdy;
    logic        rv;
    logic [15:0] ra;
    logic        dv;
    logic [15:0] da;
    logic        e_drop;
    logic        e_reqv;
    logic [15:0] e_addr;
    logic        e_hit;
    logic        e_late;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;
  int   rst_idx;

  task automatic add(input logic pv, input logic [15:0] pa, input logic rdy,
                     input logic rv, input logic [15:0] ra,
                     input logic dv, input logic [15:0] da,
                     input logic ed, input logic eqv, input logic [15:0] ea,
                     input logic eh, input logic el, input logic [15:0] ec);
    vec_t v;
    v.pv = pv; v.pa = pa; v.rdy = rdy; v.rv = rv; v.ra = ra; v.dv = dv; v.da = da;
    v.e_drop = ed; v.e_reqv = eqv; v.e_addr = ea; v.e_hit = eh; v.e_late = el; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    pf_v = 1'b0; pf_addr = 16'h0000; mem_req_ready = 1'b0;
    mem_resp_v = 1'b0; mem_resp_addr = 16'h0000; dem_v = 1'b0; dem_addr = 16'h0000;
  endtask

  // Compare all outputs against an expected set; mem_req_addr only matters while valid.
  task automatic check(input string name, input logic ed, input logic eqv, input logic [15:0] ea,
                       input logic eh, input logic el, input logic [15:0] ec);
    n_vec++;
    if (pf_drop !== ed || mem_req_v !== eqv || (eqv && mem_req_addr !== ea) ||
        dem_hit !== eh || dem_late !== el || hit_cnt !== ec) begin
      n_err++;
      $display("FAIL %s: got drop=%0b reqv=%0b addr=%h hit=%0b late=%0b cnt=%0d, want drop=%0b reqv=%0b addr=%h hit=%0b late=%0b cnt=%0d",
               name, pf_drop, mem_req_v, mem_req_addr, dem_hit, dem_late, hit_cnt,
               ed, eqv, ea, eh, el, ec);
    end
  endtask

  task automatic step(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    pf_v = v.pv; pf_addr = v.pa; mem_req_ready = v.rdy;
    mem_resp_v = v.rv; mem_resp_addr = v.ra; dem_v = v.dv; dem_addr = v.da;
    @(posedge clk);
    #1;
    check($sformatf("vec%0d", idx), v.e_drop, v.e_reqv, v.e_addr, v.e_hit, v.e_late, v.e_cnt);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // pv  pa       rdy rv  ra       dv  da        drop reqv addr    hit late cnt
    // Single candidate held on mem_req while not ready
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd0);  // 0
    add(1, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0010, 0, 0, 16'd0);  // 1
    for (int k = 0; k < 4; k++)
      add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0010, 0, 0, 16'd0); // 2-5
    // Second candidate, duplicate drop, issue in order
    add(1, 16'h0011, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0010, 0, 0, 16'd0);  // 6
    add(1, 16'h0010, 0, 0, 16'h0000, 0, 16'h0000,  1, 1, 16'h0010, 0, 0, 16'd0);  // 7
    add(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0011, 0, 0, 16'd0);  // 8
    add(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd0);  // 9
    // Fill then timely hit; repeat demand misses; late hit on ISSUED 0x0011
    add(0, 16'h0000, 0, 1, 16'h0010, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd0);  // 10
    add(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0010,  0, 0, 16'h0000, 1, 0, 16'd1);  // 11
    add(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0010,  0, 0, 16'h0000, 0, 0, 16'd1);  // 12
    add(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0011,  0, 0, 16'h0000, 0, 1, 16'd1);  // 13
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd1);  // 14
    // Fill all four entries, fifth dropped
    add(1, 16'h0020, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0020, 0, 0, 16'd1);  // 15
    add(1, 16'h0021, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0020, 0, 0, 16'd1);  // 16
    add(1, 16'h0022, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0020, 0, 0, 16'd1);  // 17
    add(1, 16'h0023, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0020, 0, 0, 16'd1);  // 18
    add(1, 16'h0024, 0, 0, 16'h0000, 0, 16'h0000,  1, 1, 16'h0020, 0, 0, 16'd1);  // 19
    // Late hit frees entry 2; the same-cycle candidate still sees a full buffer
    add(1, 16'h0030, 0, 0, 16'h0000, 1, 16'h0022,  1, 1, 16'h0020, 0, 1, 16'd1);  // 20
    add(1, 16'h0030, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0020, 0, 0, 16'd1);  // 21
    add(1, 16'h0030, 0, 0, 16'h0000, 0, 16'h0000,  1, 1, 16'h0020, 0, 0, 16'd1);  // 22
    // Drain: lowest-index QUEUED first (0x0030 sits in entry 2)
    add(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0021, 0, 0, 16'd1);  // 23
    add(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0030, 0, 0, 16'd1);  // 24
    add(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0023, 0, 0, 16'd1);  // 25
    add(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd1);  // 26
    // Fills and back-to-back hits; demand beats simultaneous fill on 0x0023
    add(0, 16'h0000, 0, 1, 16'h0020, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd1);  // 27
    add(0, 16'h0000, 0, 1, 16'h0021, 1, 16'h0020,  0, 0, 16'h0000, 1, 0, 16'd2);  // 28
    add(0, 16'h0000, 0, 1, 16'h0030, 1, 16'h0021,  0, 0, 16'h0000, 1, 0, 16'd3);  // 29
    add(0, 16'h0000, 0, 1, 16'h0023, 1, 16'h0023,  0, 0, 16'h0000, 0, 1, 16'd3);  // 30
    add(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0023,  0, 0, 16'h0000, 0, 0, 16'd3);  // 31
    add(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0030,  0, 0, 16'h0000, 1, 0, 16'd4);  // 32
    // Candidate equal to same-cycle demand address is dropped
    add(1, 16'h0050, 0, 0, 16'h0000, 1, 16'h0050,  1, 0, 16'h0000, 0, 0, 16'd4);  // 33
    add(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd4);  // 34
    // Issue 0x0040, demand before fill, stale fill ignored
    add(1, 16'h0040, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0040, 0, 0, 16'd4);  // 35
    add(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd4);  // 36
    add(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040,  0, 0, 16'h0000, 0, 1, 16'd4);  // 37
    add(0, 16'h0000, 0, 1, 16'h0040, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd4);  // 38
    add(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040,  0, 0, 16'h0000, 0, 0, 16'd4);  // 39
    // Handshake and demand free on the same entry in the same cycle
    add(1, 16'h0041, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0041, 0, 0, 16'd4);  // 40
    add(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0041,  0, 0, 16'h0000, 0, 1, 16'd4);  // 41
    add(1, 16'h0041, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0041, 0, 0, 16'd4);  // 42
    add(1, 16'h0042, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0041, 0, 0, 16'd4);  // 43
    add(1, 16'h0043, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0041, 0, 0, 16'd4);  // 44
    add(1, 16'h0041, 0, 0, 16'h0000, 0, 16'h0000,  1, 1, 16'h0041, 0, 0, 16'd4);  // 45
    rst_idx = vecs.size();
    // After mid-cycle reset: old fill and demand have no effect
    add(0, 16'h0000, 0, 1, 16'h0041, 0, 16'h0000,  0, 0, 16'h0000, 0, 0, 16'd0);  // 46
    add(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0041,  0, 0, 16'h0000, 0, 0, 16'd0);  // 47
    add(1, 16'h0041, 0, 0, 16'h0000, 0, 16'h0000,  0, 1, 16'h0041, 0, 0, 16'd0);  // 48
    add(1, 16'h0041, 0, 0, 16'h0000, 0, 16'h0000,  1, 1, 16'h0041, 0, 0, 16'd0);  // 49

    // Power-on reset
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == rst_idx) begin
        // Asynchronous reset mid-cycle with three live entries and a pending drop pulse
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
      end
      step(i);
    end

    @(negedge clk);
    drive_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
